data_bus_ram_responder: RTL and testbench

DATA_BUS_RAM_RESPONDER -- requirements
Module: data_bus_ram_responder

---
 rtl/data_bus_ram_responder.sv | 151 +++++++++++++++
 tb/tb_data_bus_ram_responder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/data_bus_ram_responder.sv
// Data-bus RAM responder: latches one byte/half/word access, inserts WAIT_CYCLES
// wait states, then completes with a one-cycle db_ready strobe.
module data_bus_ram_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] db_addr,
  input  logic [31:0] db_dataIn,
  input  logic [2:0]  db_accessType,
  output logic [31:0] db_dataOut,
  output logic        db_ready,
  output logic        db_addrErr,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int WC_M1 = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  state_t              state, state_nx;
  req_t                req_q, req_cur;
  logic [3:0]          cnt, cnt_nx;
  logic                req_valid, load, enter_done;
  logic [1:0]          size;
  logic [31:0]         acc_addr;
  logic [ADDR_W-1:0]   idx;
  logic                mis;
  logic [3:0]          be;
  logic [31:0]         wdata, rdata;
  logic [3:0][7:0]     rword;
  logic                err_q;
  logic                unused_addr;

  logic [3:0][7:0] mem [DEPTH];

  // 000 and the reserved 100 both mean "no access"
  assign req_valid = db_accessType[1:0] != 2'b00;

  // In IDLE the live bus is decoded so WAIT_CYCLES=0 can commit on the sampling edge
  assign req_cur  = (state == IDLE) ? req_t'({db_accessType, db_addr, db_dataIn}) : req_q;
  assign size     = req_cur.typ[1:0];
  assign acc_addr = req_cur.addr;
  assign idx      = acc_addr[ADDR_W+1:2];
  assign unused_addr = ^{acc_addr[31:ADDR_W+2]};

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    load       = 1'b0;
    enter_done = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          load = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nx   = DONE;
            enter_done = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = 4'(WC_M1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx   = DONE;
          enter_done = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane enables and lane-replicated write data
  always_comb begin
    be    = 4'b0000;
    mis   = 1'b0;
    wdata = req_cur.data;
    case (size)
      2'b01: begin
        be    = 4'b0001 << acc_addr[1:0];
        wdata = {4{req_cur.data[7:0]}};
      end
      2'b10: begin
        mis   = acc_addr[0];
        be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{req_cur.data[15:0]}};
      end
      2'b11: begin
        mis = acc_addr[1:0] != 2'b00;
        be  = 4'b1111;
      end
      default: ;
    endcase
  end

  assign rword = mem[idx];

  always_comb begin
    rdata = '0;
    case (size)
      2'b01:   rdata = {24'd0, rword[acc_addr[1:0]]};
      2'b10:   rdata = {16'd0, acc_addr[1] ? rword[3:2] : rword[1:0]};
      2'b11:   rdata = rword;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_q      <= '0;
      err_q      <= 1'b0;
      db_dataOut <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (load) req_q <= req_cur;
      if (enter_done) begin
        err_q      <= mis;
        db_dataOut <= (!req_cur.typ[2] && !mis) ? rdata : '0;
      end
    end
  end

  // RAM is never cleared; a commit edge that meets an asserted reset is dropped
  always_ff @(posedge clk) begin
    if (res && enter_done && req_cur.typ[2] && !mis) begin
      for (int l = 0; l < 4; l++)
        if (be[l]) mem[idx][l] <= wdata[8*l +: 8];
    end
  end

  assign db_ready   = (state == DONE);
  assign db_addrErr = (state == DONE) && err_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_data_bus_ram_responder.sv
// Directed bench: one responder with WAIT_CYCLES=2 and one with WAIT_CYCLES=0.
module tb_data_bus_ram_responder;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] a_addr, a_din, a_dout;
  logic [2:0]  a_type;
  logic        a_ready, a_err, a_busy;
  logic [31:0] b_addr, b_din, b_dout;
  logic [2:0]  b_type;
  logic        b_ready, b_err, b_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_bus_ram_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .res(res), .db_addr(a_addr), .db_dataIn(a_din),
    .db_accessType(a_type), .db_dataOut(a_dout), .db_ready(a_ready),
    .db_addrErr(a_err), .busy(a_busy));

  data_bus_ram_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .res(res), .db_addr(b_addr), .db_dataIn(b_din),
    .db_accessType(b_type), .db_dataOut(b_dout), .db_ready(b_ready),
    .db_addrErr(b_err), .busy(b_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on the WAIT_CYCLES=2 responder; bus is scrambled while waiting
  task automatic acc_a(input string tag, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, input logic exp_err, input logic [31:0] exp_data);
    a_type = t; a_addr = a; a_din = d;
    tick();
    chk({tag, ".busy"}, 32'(a_busy), 32'd1);
    chk({tag, ".rdy0"}, 32'(a_ready), 32'd0);
    a_type = 3'b111; a_addr = 32'h10; a_din = 32'hFFFF_FFFF;
    tick();
    chk({tag, ".rdy1"}, 32'(a_ready), 32'd0);
    a_type = 3'b000; a_addr = 32'h0; a_din = 32'h0;
    tick();
    chk({tag, ".rdy2"}, 32'(a_ready), 32'd1);
    chk({tag, ".err"},  32'(a_err), 32'(exp_err));
    chk({tag, ".data"}, a_dout, exp_data);
    tick();
    chk({tag, ".rdy3"}, 32'(a_ready), 32'd0);
    chk({tag, ".idle"}, 32'(a_busy), 32'd0);
    chk({tag, ".hold"}, a_dout, exp_data);
  endtask

  initial begin
    res = 1'b0;
    a_type = 3'b000; a_addr = '0; a_din = '0;
    b_type = 3'b000; b_addr = '0; b_din = '0;
    tick(); tick();
    chk("rst.ready", 32'(a_ready), 32'd0);
    chk("rst.err",   32'(a_err), 32'd0);
    chk("rst.busy",  32'(a_busy), 32'd0);
    chk("rst.dout",  a_dout, 32'd0);
    chk("rst.b_busy", 32'(b_busy), 32'd0);
    res = 1'b1;
    tick();

    acc_a("wr_w10",  3'b111, 32'h10, 32'h1122_3344, 1'b0, 32'h0);
    acc_a("rd_w10",  3'b011, 32'h10, 32'h0, 1'b0, 32'h1122_3344);
    acc_a("wr_b12",  3'b101, 32'h12, 32'hFFFF_FFAB, 1'b0, 32'h0);
    acc_a("rd_h12",  3'b010, 32'h12, 32'h0, 1'b0, 32'h0000_11AB);
    acc_a("rd_w10b", 3'b011, 32'h10, 32'h0, 1'b0, 32'h11AB_3344);
    acc_a("rd_b11",  3'b001, 32'h11, 32'h0, 1'b0, 32'h0000_0033);
    acc_a("rd_b13",  3'b001, 32'h13, 32'h0, 1'b0, 32'h0000_0011);
    acc_a("rd_h10",  3'b010, 32'h10, 32'h0, 1'b0, 32'h0000_3344);
    acc_a("mis_w",   3'b011, 32'h1012, 32'h0, 1'b1, 32'h0);
    acc_a("alias",   3'b011, 32'h1010, 32'h0, 1'b0, 32'h11AB_3344);
    acc_a("mis_wrh", 3'b110, 32'h11, 32'h0000_BEEF, 1'b1, 32'h0);
    acc_a("rd_nowr", 3'b011, 32'h10, 32'h0, 1'b0, 32'h11AB_3344);
    acc_a("wr_h16",  3'b110, 32'h16, 32'h1234_5566, 1'b0, 32'h0);
    acc_a("rd_h16",  3'b010, 32'h16, 32'h0, 1'b0, 32'h0000_5566);
    acc_a("wr_w20",  3'b111, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0);
    acc_a("rd_w20",  3'b011, 32'h20, 32'h0, 1'b0, 32'hCAFE_F00D);

    // Reset pulse while a write waits: nothing completes, RAM keeps old value
    a_type = 3'b111; a_addr = 32'h20; a_din = 32'hDEAD_BEEF;
    tick();
    chk("rstw.busy_pre", 32'(a_busy), 32'd1);
    a_type = 3'b000; a_addr = '0; a_din = '0;
    res = 1'b0;
    #1;
    chk("rstw.busy", 32'(a_busy), 32'd0);
    chk("rstw.rdy",  32'(a_ready), 32'd0);
    chk("rstw.dout", a_dout, 32'd0);
    tick();
    res = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstw.no_rdy", 32'(a_ready), 32'd0);
    end
    acc_a("rd_w20r", 3'b011, 32'h20, 32'h0, 1'b0, 32'hCAFE_F00D);

    // Zero-wait responder: single write, then a read held for four cycles
    b_type = 3'b111; b_addr = 32'h10; b_din = 32'h0BAD_F00D;
    tick();
    chk("b_wr.rdy", 32'(b_ready), 32'd1);
    chk("b_wr.err", 32'(b_err), 32'd0);
    chk("b_wr.dout", b_dout, 32'd0);
    b_type = 3'b011; b_din = 32'h0;
    tick();
    chk("b_wr.rdy_off", 32'(b_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b_hold.rdy", 32'(b_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("b_hold.dout", b_dout, 32'h0BAD_F00D);
    end
    b_type = 3'b000;
    tick();
    chk("b_end.busy", 32'(b_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
